// File: rtl/vconv_unit_pkg.sv
// Shared types and sizing for the vector convolution unit.
// Lane count, lane width, kernel limit and accumulator width live here.
package vconv_unit_pkg;

    localparam int LENGTH = 16;
    localparam int DW     = 8;
    localparam int KMAX   = 9;
    localparam int ACC_W  = 2 * DW + $clog2(KMAX);
    localparam int KS_W   = 4;
    localparam int ADDR_W = 5;
    localparam int SH_W   = 4;
    localparam int IDX_W  = $clog2(LENGTH);

    localparam logic [KS_W-1:0] KMAX_KS = KS_W'(KMAX);

    typedef enum logic [1:0] {
        VC_IDLE  = 2'd0,
        VC_MAC   = 2'd1,
        VC_QUANT = 2'd2,
        VC_WRITE = 2'd3
    } vc_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [SH_W-1:0]   shift;
        logic              relu;
        logic [KS_W-1:0]   ks;
    } vc_cfg_t;

    // A zero-tap kernel still needs one tap; anything past KMAX is cut back.
    function automatic logic [KS_W-1:0] clamp_ks(input logic [KS_W-1:0] k);
        if (k == '0)
            return KS_W'(1);
        if (k > KMAX_KS)
            return KMAX_KS;
        return k;
    endfunction

endpackage

// File: rtl/vconv_unit_if.sv
// Request/write-back bundle between the register file and the convolution unit.
// The unit sits on the slave side; the register file / pipeline drives master.
interface vconv_unit_if;
    import vconv_unit_pkg::*;

    logic                  start;
    logic [LENGTH*DW-1:0]  rA_data;
    logic [LENGTH*DW-1:0]  rB_data;
    logic [KS_W-1:0]       ksize;
    logic [ADDR_W-1:0]     dst_addr;
    logic [SH_W-1:0]       shift;
    logic                  relu_en;
    logic                  wb_block;
    logic                  busy;
    logic                  done;
    logic [LENGTH*DW-1:0]  conv_result;
    logic [ADDR_W-1:0]     conv_addr;
    logic                  conv_write;

    modport slave (
        input  start, rA_data, rB_data, ksize, dst_addr, shift, relu_en, wb_block,
        output busy, done, conv_result, conv_addr, conv_write
    );

    modport master (
        output start, rA_data, rB_data, ksize, dst_addr, shift, relu_en, wb_block,
        input  busy, done, conv_result, conv_addr, conv_write
    );

endinterface

// File: rtl/vconv_unit_lane.sv
// One output lane: zero-padded tap select, signed MAC, then round/shift/saturate/ReLU.
// The result register holds its value until the next QUANT cycle.
module vconv_lane
    import vconv_unit_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         mac_en,
    input  logic                         quant_en,
    input  logic [LENGTH-1:0][DW-1:0]    vec,
    input  logic signed [DW-1:0]         w,
    input  logic signed [5:0]            offs,
    input  logic [SH_W-1:0]              shift,
    input  logic                         relu,
    output logic [DW-1:0]                res
);

    localparam logic signed [6:0]     LEN_S = 7'(LENGTH);
    localparam logic signed [ACC_W:0] QMAX  = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] QMIN  = (ACC_W+1)'(-128);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DW-1:0]           res_q, res_d;
    logic signed [6:0]       idx;
    logic signed [DW-1:0]    x;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W:0]   rnd, sum, shr;

    always_comb begin
        // Source lane for this tap; anything off either end reads as zero.
        idx = $signed(7'(LANE)) + $signed({offs[5], offs});
        x   = '0;
        if (idx >= 7'sd0 && idx < LEN_S)
            x = vec[idx[IDX_W-1:0]];
        prod = x * w;

        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (mac_en)
            acc_d = acc_q + ACC_W'(prod);

        // One extra bit so the rounding add cannot wrap.
        rnd = '0;
        if (shift != '0)
            rnd = (ACC_W+1)'(1) << (shift - SH_W'(1));
        sum = $signed({acc_q[ACC_W-1], acc_q}) + rnd;
        shr = sum >>> shift;

        res_d = res_q;
        if (quant_en) begin
            if (relu && shr[ACC_W])
                res_d = '0;
            else if (shr > QMAX)
                res_d = 8'h7f;
            else if (shr < QMIN)
                res_d = 8'h80;
            else
                res_d = shr[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: rtl/vconv_unit.sv
// Multi-cycle 1-D INT8 convolution: one kernel tap per cycle across all lanes,
// then requantize and hand the vector to the register file's secondary write port.
module vconv_unit
    import vconv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    vconv_unit_if.slave  bus
);

    vc_state_t                state_q, state_d;
    vc_cfg_t                  cfg_q, cfg_d;
    logic [LENGTH-1:0][DW-1:0] a_q, a_d;
    logic [LENGTH-1:0][DW-1:0] b_q, b_d;
    logic [KS_W-1:0]          k_q, k_d;
    logic [KS_W-1:0]          half;
    logic signed [5:0]        offs;
    logic                     clr, mac_en, quant_en;
    logic [LENGTH-1:0][DW-1:0] res;

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        clr      = 1'b0;
        mac_en   = 1'b0;
        quant_en = 1'b0;

        case (state_q)
            VC_IDLE: begin
                if (bus.start) begin
                    a_d         = bus.rA_data;
                    b_d         = bus.rB_data;
                    cfg_d.dst   = bus.dst_addr;
                    cfg_d.shift = bus.shift;
                    cfg_d.relu  = bus.relu_en;
                    cfg_d.ks    = clamp_ks(bus.ksize);
                    k_d         = '0;
                    clr         = 1'b1;
                    state_d     = VC_MAC;
                end
            end
            VC_MAC: begin
                mac_en = 1'b1;
                k_d    = k_q + KS_W'(1);
                if (k_q == cfg_q.ks - KS_W'(1))
                    state_d = VC_QUANT;
            end
            VC_QUANT: begin
                quant_en = 1'b1;
                state_d  = VC_WRITE;
            end
            VC_WRITE: begin
                if (!bus.wb_block)
                    state_d = VC_IDLE;
            end
            default: state_d = VC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= VC_IDLE;
            cfg_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
        end
    end

    // Centre the kernel: tap k reads lane i + k - (ks-1)/2.
    assign half = (cfg_q.ks - KS_W'(1)) >> 1;
    assign offs = $signed({2'b00, k_q}) - $signed({2'b00, half});

    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        vconv_lane #(.LANE(i)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clr      (clr),
            .mac_en   (mac_en),
            .quant_en (quant_en),
            .vec      (a_q),
            .w        ($signed(b_q[k_q])),
            .offs     (offs),
            .shift    (cfg_q.shift),
            .relu     (cfg_q.relu),
            .res      (res[i])
        );
    end

    // The write strobe must drop in the same cycle the pipeline claims the port.
    assign bus.busy        = (state_q != VC_IDLE);
    assign bus.conv_write  = (state_q == VC_WRITE) && !bus.wb_block;
    assign bus.done        = (state_q == VC_WRITE) && !bus.wb_block;
    assign bus.conv_addr   = cfg_q.dst;
    assign bus.conv_result = res;

endmodule

// File: tb/tb_vconv_unit.sv
// Directed bench for vconv_unit: arithmetic reference model plus hand-computed lane values.
module tb_vconv_unit;
    import vconv_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vconv_unit_if bus();
    vconv_unit dut (.clk(clk), .reset(reset), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [127:0] res;
        logic [4:0]   addr;
    } exp_t;
    exp_t exp_q[$];

    logic [127:0] last_res;
    logic [4:0]   last_addr;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic int lane(input logic [127:0] v, input int i);
        return int'($signed(v[8*i +: 8]));
    endfunction

    // Straight arithmetic definition of the job result.
    function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input int ksz, input int sh, input bit relu);
        int ks, acc, r, j;
        logic [127:0] out;
        ks = (ksz == 0) ? 1 : ((ksz > 9) ? 9 : ksz);
        out = '0;
        for (int i = 0; i < 16; i++) begin
            acc = 0;
            for (int k = 0; k < ks; k++) begin
                j = i + k - (ks - 1) / 2;
                if (j >= 0 && j < 16)
                    acc += int'($signed(a[8*j +: 8])) * int'($signed(b[8*k +: 8]));
            end
            r = acc + ((sh > 0) ? (1 << (sh - 1)) : 0);
            r = r >>> sh;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            if (relu && r < 0) r = 0;
            out[8*i +: 8] = r[7:0];
        end
        return out;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.conv_write) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_write: conv_write=1 at cycle %0d, no job pending", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_result", bus.conv_result, e.res);
                    chk("wb_addr", 128'(bus.conv_addr), 128'(e.addr));
                    chk("wb_done", 128'(bus.done), 128'd1);
                end
            end else begin
                chk("done_without_write", 128'(bus.done), 128'd0);
            end
        end
    end

    task automatic drive(input logic [127:0] a, input logic [127:0] b, input logic [3:0] ksz,
                         input logic [4:0] dst, input logic [3:0] sh, input bit relu);
        bus.start    = 1'b1;
        bus.rA_data  = a;
        bus.rB_data  = b;
        bus.ksize    = ksz;
        bus.dst_addr = dst;
        bus.shift    = sh;
        bus.relu_en  = relu;
    endtask

    task automatic run_job(input string nm, input logic [127:0] a, input logic [127:0] b,
                           input logic [3:0] ksz, input logic [4:0] dst, input logic [3:0] sh,
                           input bit relu, input int stall, input bit poke, input int exp_lat);
        exp_t e;
        int t0, lat;
        bit seen;
        e.res  = model(a, b, int'(ksz), int'(sh), relu);
        e.addr = dst;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive(a, b, ksz, dst, sh, relu);
        bus.wb_block = (stall > 0);
        t0 = cyc;
        seen = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.rA_data  = ~a;
        bus.dst_addr = ~dst;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.conv_write) begin
                seen = 1'b1;
                lat = cyc - t0;
                last_res = bus.conv_result;
                last_addr = bus.conv_addr;
            end else begin
                if (stall > 0 && cyc >= t0 + exp_lat - stall) begin
                    chk({nm, "_stall_result"}, bus.conv_result, e.res);
                    chk({nm, "_stall_addr"}, 128'(bus.conv_addr), 128'(dst));
                end
                @(posedge clk); #1;
                if (cyc >= t0 + exp_lat) bus.wb_block = 1'b0;
                bus.start = poke && (cyc == t0 + 2);
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            n_total++;
            $display("FAIL %s_timeout: no conv_write within 40 cycles, want latency %0d", nm, exp_lat);
            exp_q.delete();
        end else begin
            chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a_id, ra, rb;
        logic [3:0] rk;
        exp_t e;
        int t0;
        for (int i = 0; i < 16; i++) a_id[8*i +: 8] = 8'(i);
        bus.start = 1'b0; bus.rA_data = '0; bus.rB_data = '0; bus.ksize = '0;
        bus.dst_addr = '0; bus.shift = '0; bus.relu_en = 1'b0; bus.wb_block = 1'b0;

        #1 reset = 1'b1;
        #2;
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_write", 128'(bus.conv_write), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_result", bus.conv_result, 128'd0);
        chk("rst_addr", 128'(bus.conv_addr), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_job("ident", a_id, 128'h01, 4'd1, 5'd7, 4'd0, 1'b0, 0, 1'b0, 3);
        chk("ident_l0", 128'(lane(last_res, 0)), 128'(0));
        chk("ident_l15", 128'(lane(last_res, 15)), 128'(15));
        chk("ident_addr", 128'(last_addr), 128'(7));

        run_job("ones3", {16{8'h01}}, 128'h010101, 4'd3, 5'd3, 4'd0, 1'b0, 0, 1'b0, 5);
        chk("ones3_l0", 128'(lane(last_res, 0)), 128'(2));
        chk("ones3_l7", 128'(lane(last_res, 7)), 128'(3));
        chk("ones3_l15", 128'(lane(last_res, 15)), 128'(2));

        run_job("satpos", {16{8'h7f}}, 128'h7f7f7f, 4'd3, 5'd1, 4'd0, 1'b0, 0, 1'b0, 5);
        chk("satpos_l0", 128'(lane(last_res, 0)), 128'(127));
        chk("satpos_l7", 128'(lane(last_res, 7)), 128'(127));
        run_job("satneg", {16{8'h80}}, 128'h7f7f7f, 4'd3, 5'd2, 4'd0, 1'b0, 0, 1'b0, 5);
        chk("satneg_l7", 128'(lane(last_res, 7)), 128'(-128));
        run_job("relu", {16{8'h80}}, 128'h7f7f7f, 4'd3, 5'd2, 4'd0, 1'b1, 0, 1'b0, 5);
        chk("relu_l7", 128'(lane(last_res, 7)), 128'(0));

        run_job("round", 128'h01fd03, 128'h01, 4'd1, 5'd4, 4'd1, 1'b0, 0, 1'b0, 3);
        chk("round_p3", 128'(lane(last_res, 0)), 128'(2));
        chk("round_m3", 128'(lane(last_res, 1)), 128'(-1));
        chk("round_p1", 128'(lane(last_res, 2)), 128'(1));

        run_job("even4", a_id, 128'h01020304, 4'd4, 5'd5, 4'd2, 1'b0, 0, 1'b0, 6);
        chk("even4_l5", 128'(lane(last_res, 5)), 128'(13));
        chk("even4_l15", 128'(lane(last_res, 15)), 128'(25));

        run_job("stall", a_id, 128'hff0201, 4'd3, 5'd9, 4'd0, 1'b0, 2, 1'b1, 7);
        chk("stall_l5", 128'(lane(last_res, 5)), 128'(8));
        chk("stall_addr", 128'(last_addr), 128'(9));

        // Abort a 9-tap job in its fourth MAC cycle.
        e.res = '0; e.addr = '0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive(a_id, {16{8'h01}}, 4'd9, 5'd11, 4'd0, 1'b0);
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_mac", 128'(cyc - t0), 128'(4));
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_busy", 128'(bus.busy), 128'd0);
        chk("abort_write", 128'(bus.conv_write), 128'd0);
        chk("abort_result", bus.conv_result, 128'd0);
        chk("abort_addr", 128'(bus.conv_addr), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (15) @(posedge clk);
        run_job("after_abort", a_id, {16{8'h01}}, 4'd9, 5'd11, 4'd0, 1'b0, 0, 1'b0, 11);
        chk("after_abort_l7", 128'(lane(last_res, 7)), 128'(63));

        run_job("ks0", a_id, 128'h0502, 4'd0, 5'd6, 4'd0, 1'b0, 0, 1'b0, 3);
        chk("ks0_l6", 128'(lane(last_res, 6)), 128'(12));
        run_job("ks15", {16{8'h01}}, {{7{8'h05}}, {9{8'h01}}}, 4'd15, 5'd8, 4'd0, 1'b0, 0, 1'b0, 11);
        chk("ks15_l7", 128'(lane(last_res, 7)), 128'(9));
        chk("ks15_l0", 128'(lane(last_res, 0)), 128'(5));

        for (int n = 0; n < 4; n++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rk = 4'($urandom_range(1, 9));
            run_job("rand", ra, rb, rk, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 0, 1'b0, int'(rk) + 2);
        end

        repeat (20) @(posedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vconv_unit.md
Name: vconv_unit

Overview:
- Multi-cycle 1-D convolution engine for the vector datapath.
- Takes a feature vector (rA_data) and a kernel vector (rB_data) read from the vector register file. Convolves across the `LENGTH INT8 lanes with zero padding.
- Requantizes each lane to INT8 and writes the result back through the register file's conv_result/conv_addr/conv_write port.
- Sits between the vector register file read ports and its secondary write port.

Parameters:
- LENGTH, `LENGTH (16), number of INT8 lanes per vector.
- DW, `INT8 (8), lane width in bits.
- KMAX, 9, maximum kernel taps; taps are taken from the low KMAX bytes of rB_data.
- ACC_W, 2*DW+$clog2(KMAX), signed accumulator width per lane.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; operands are sampled on this edge.
- rA_data  in  LENGTH*DW  input vector; lane i = bits [DW*i+DW-1:DW*i], signed.
- rB_data  in  LENGTH*DW  kernel; tap k = byte k, signed.
- ksize  in  4  number of taps.
- dst_addr  in  5  destination vector register.
- shift  in  4  requantization right-shift amount.
- relu_en  in  1  clamp negative results to 0.
- wb_block  in  1  write-back stall; high while the pipeline owns the register-file write port.
- busy  out  1  high from the cycle after start is accepted until write-back completes.
- done  out  1  one-cycle pulse, coincident with conv_write.
- conv_result  out  LENGTH*DW  requantized result vector.
- conv_addr  out  5  latched dst_addr.
- conv_write  out  1  write strobe to the register file.

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0, all accumulators 0, state IDLE. Reset mid-operation aborts the job with no write-back.
- States: IDLE, MAC, QUANT, WRITE.
- IDLE:
  - start=1 latches rA, rB, dst_addr, shift and relu_en.
  - ksize is latched with clamping: 0 becomes 1, values above KMAX become KMAX.
  - Accumulators are cleared, tap counter k=0, state goes to MAC.
- Any start while not IDLE is ignored.
- MAC:
  - One tap per cycle: acc[i] += in[i+k-(ks-1)/2] * w[k], signed 8x8 multiply.
  - Out-of-range lane indices contribute 0.
  - Leaves for QUANT after the tap with k=ks-1, i.e. after ks cycles.
- QUANT, one cycle, per lane:
  - r = acc + (shift>0 ? 1<<(shift-1) : 0), then arithmetic shift right by shift.
  - Saturate to [-128,127]; if relu_en and r<0, r=0.
  - r is registered into conv_result. State goes to WRITE.
- WRITE:
  - conv_write = !wb_block. conv_result and conv_addr are held stable throughout.
  - On the first cycle with wb_block=0: conv_write=1 and done=1 for exactly that cycle, then IDLE.
  - While wb_block=1 the block stays in WRITE.
- Latency with no stall: conv_write is high ks+2 cycles after the start cycle.
- Throughput: one job per ks+3 cycles. start may be asserted again in the cycle after done.
- conv_result holds its last value in IDLE. conv_write is never high outside WRITE.

Decomposition:
- def.v gains KMAX and ACC_W defines next to `LENGTH/`INT8, plus the state encodings VC_IDLE/VC_MAC/VC_QUANT/VC_WRITE.
- Sub-module vconv_lane, generated LENGTH times, holds:
  - the per-lane accumulator;
  - the signed multiply with zero-pad select;
  - round/shift/saturate/ReLU.
- The top level holds the FSM, tap counter, operand latches and write-back handshake.

Test Plan:
- Identity, ks=1, w0=1, shift=0, in lanes=0..15 -> conv_result lanes 0..15, conv_addr=dst, conv_write/done high 3 cycles after start for one cycle.
- ks=3, w={1,1,1}, all inputs 1 -> lanes 0 and 15 = 2, lanes 1..14 = 3; conv_write 5 cycles after start.
- Saturation, ks=3, w=127, inputs 127 -> all lanes 127. Inputs -128 with w=127 -> -128; same with relu_en=1 -> 0.
- Rounding, ks=1, w=1, shift=1: in=3 -> 2; in=-3 -> -1; in=1 -> 1.
- wb_block high for 2 cycles on entry to WRITE -> conv_write deferred 2 cycles; conv_result/conv_addr unchanged; single write; start during busy ignored (no second write).
- Reset asserted mid-MAC (ks=9, cycle 4) -> immediate zero outputs, no conv_write. A fresh start after release yields the correct result.
- ksize=0 behaves as 1; ksize=15 behaves as 9 (latency 11 cycles).
